// File: rtl/wake_vote_ctrl_if.sv
// Frame stream from the classifier plus the wake-event handshake to downstream logic.
// Signal suffixes are relative to the vote controller (slave side).
interface wake_vote_ctrl_if #(
    parameter int unsigned NUM_CLASSES = 3
);
    logic [NUM_CLASSES-1:0] data_i;
    logic                   valid_i;
    logic                   last_i;
    logic                   ready_o;
    logic                   wake_valid_o;
    logic                   wake_ready_i;

    // Classifier side: drives frames, consumes the wake event.
    modport master (
        output data_i,
        output valid_i,
        output last_i,
        input  ready_o,
        input  wake_valid_o,
        output wake_ready_i
    );

    // Vote controller side.
    modport slave (
        input  data_i,
        input  valid_i,
        input  last_i,
        output ready_o,
        output wake_valid_o,
        input  wake_ready_i
    );
endinterface

// File: rtl/wake_vote_ctrl.sv
// Wake decision stage: sliding-window vote over wake-class hits, one wake event
// per threshold crossing, then a programmable cooldown before re-arming.
module wake_vote_ctrl #(
    parameter int unsigned   NUM_CLASSES  = 3,
    parameter int unsigned   WINDOW       = 8,
    parameter int unsigned   CD_BW        = 24,
    parameter int unsigned   DEF_THRESH   = 5,
    parameter int unsigned   DEF_COOLDOWN = 8000000,
    localparam int unsigned  TH_BW        = $clog2(WINDOW + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              cfg_we_i,
    input  logic [TH_BW-1:0]  cfg_thresh_i,
    input  logic [CD_BW-1:0]  cfg_cooldown_i,
    wake_vote_ctrl_if.slave   bus,
    output logic              busy_o,
    output logic [TH_BW-1:0]  hit_count_o
);

    typedef enum logic [1:0] {
        ST_ARMED    = 2'd0,
        ST_REPORT   = 2'd1,
        ST_COOLDOWN = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WINDOW-1:0]   hist_q, hist_d;
    logic [CD_BW-1:0]    cd_cnt_q, cd_cnt_d;
    logic [TH_BW-1:0]    thresh_q;
    logic [CD_BW-1:0]    cd_len_q;

    logic                accept;
    logic [WINDOW-1:0]   hist_shift;
    logic [TH_BW-1:0]    cnt_next;
    logic                fire;
    logic                cd_done;
    logic                ready;
    logic                unused_data;

    function automatic logic [TH_BW-1:0] popcount(input logic [WINDOW-1:0] v);
        logic [TH_BW-1:0] c;
        c = '0;
        for (int unsigned i = 0; i < WINDOW; i++) begin
            c = c + TH_BW'(v[i]);
        end
        return c;
    endfunction

    // Only the wake-word class participates in the vote.
    assign unused_data = ^bus.data_i;

    assign accept     = bus.valid_i & ready;
    assign hist_shift = WINDOW'({hist_q, bus.data_i[0]});
    assign cnt_next   = popcount(hist_shift);
    assign fire       = (thresh_q != '0) && (cnt_next >= thresh_q);
    // A live shrink to zero must also end the cooldown rather than wrap the compare.
    assign cd_done    = (cd_len_q == '0) || (cd_cnt_q >= (cd_len_q - CD_BW'(1)));

    assign hit_count_o = popcount(hist_q);

    // Configuration registers, writable in any state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            thresh_q <= TH_BW'(DEF_THRESH);
            cd_len_q <= CD_BW'(DEF_COOLDOWN);
        end else if (cfg_we_i) begin
            thresh_q <= cfg_thresh_i;
            cd_len_q <= cfg_cooldown_i;
        end
    end

    // State, history and cooldown counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_ARMED;
            hist_q   <= '0;
            cd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            hist_q   <= hist_d;
            cd_cnt_q <= cd_cnt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        hist_d   = hist_q;
        cd_cnt_d = cd_cnt_q;
        case (state_q)
            ST_ARMED: begin
                if (!enable_i) begin
                    hist_d = '0;
                end else if (accept) begin
                    // Threshold wins over the end-of-utterance clear.
                    if (fire) begin
                        state_d = ST_REPORT;
                        hist_d  = '0;
                    end else if (bus.last_i) begin
                        hist_d = '0;
                    end else begin
                        hist_d = hist_shift;
                    end
                end
            end
            ST_REPORT: begin
                hist_d = '0;
                if (bus.wake_ready_i) begin
                    cd_cnt_d = '0;
                    state_d  = (cd_len_q == '0) ? ST_ARMED : ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                hist_d = '0;
                if (cd_done) begin
                    state_d = ST_ARMED;
                end else begin
                    cd_cnt_d = cd_cnt_q + CD_BW'(1);
                end
            end
            default: begin
                state_d  = ST_ARMED;
                hist_d   = '0;
                cd_cnt_d = '0;
            end
        endcase
    end

    // Output decode from the state register.
    always_comb begin
        ready            = 1'b0;
        bus.wake_valid_o = 1'b0;
        busy_o           = 1'b1;
        case (state_q)
            ST_ARMED: begin
                ready  = 1'b1;
                busy_o = 1'b0;
            end
            ST_REPORT: begin
                bus.wake_valid_o = 1'b1;
            end
            ST_COOLDOWN: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    assign bus.ready_o = ready;

endmodule

// File: tb/tb_wake_vote_ctrl.sv
// Scenario bench for wake_vote_ctrl: expected per-frame results are queued as
// frames are driven and popped once the DUT has registered the frame.
module tb_wake_vote_ctrl;

    localparam int unsigned NC  = 3;
    localparam int unsigned WIN = 8;
    localparam int unsigned CDW = 24;
    localparam int unsigned TH  = $clog2(WIN + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic           cfg_we;
    logic [TH-1:0]  cfg_thresh;
    logic [CDW-1:0] cfg_cd;
    logic           busy;
    logic [TH-1:0]  hit;

    wake_vote_ctrl_if #(.NUM_CLASSES(NC)) bus ();

    wake_vote_ctrl #(
        .NUM_CLASSES (NC),
        .WINDOW      (WIN),
        .CD_BW       (CDW),
        .DEF_THRESH  (5),
        .DEF_COOLDOWN(8000000)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .cfg_we_i      (cfg_we),
        .cfg_thresh_i  (cfg_thresh),
        .cfg_cooldown_i(cfg_cd),
        .bus           (bus),
        .busy_o        (busy),
        .hit_count_o   (hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          wake;
        logic [TH-1:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t mk(input logic w, input int c);
        exp_t e;
        e.wake = w;
        e.cnt  = TH'(c);
        return e;
    endfunction

    // One frame offered for one clock; returns #1 after the sampling edge.
    task automatic drive(input logic d0, input logic lst);
        logic [NC-2:0] upper;
        upper = (NC-1)'($urandom);
        @(negedge clk);
        bus.data_i  = {upper, d0};
        bus.valid_i = 1'b1;
        bus.last_i  = lst;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        bus.last_i  = 1'b0;
    endtask

    task automatic cfg_write(input int th, input int cd);
        @(negedge clk);
        cfg_we     = 1'b1;
        cfg_thresh = TH'(th);
        cfg_cd     = CDW'(cd);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic handshake();
        @(negedge clk);
        bus.wake_ready_i = 1'b1;
        @(posedge clk);
        #1;
        bus.wake_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        int   n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.ready_o, bus.wake_valid_o, busy, hit} !== {1'b1, 1'b0, 1'b0, TH'(0)}) begin
            failures++;
            $display("FAIL reset_init: ready=%b wake=%b busy=%b hit=%0d, expected 1 0 0 0",
                     bus.ready_o, bus.wake_valid_o, busy, hit);
        end
        rst = 1'b0;
        cfg_write(2, 50);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        checks++;
        if (bus.wake_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_prefire: wake=%b, expected 1", bus.wake_valid_o);
        end
        handshake();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_cooldown: busy=%b, expected 1", busy);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({bus.ready_o, bus.wake_valid_o, busy, hit} !== {1'b1, 1'b0, 1'b0, TH'(0)}) begin
            failures++;
            $display("FAIL reset_mid_cooldown: ready=%b wake=%b busy=%b hit=%0d, expected 1 0 0 0",
                     bus.ready_o, bus.wake_valid_o, busy, hit);
        end
        // Default threshold of 5: fires on the fifth hit, not before.
        for (int i = 1; i <= 4; i++) sb.push_back(mk(1'b0, i));
        sb.push_back(mk(1'b1, 0));
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (bus.wake_valid_o !== e.wake || hit !== e.cnt) begin
                failures++;
                $display("FAIL default_thresh frame %0d: wake=%b hit=%0d, expected wake=%b hit=%0d",
                         i, bus.wake_valid_o, hit, e.wake, e.cnt);
            end
        end
        cfg_write(3, 4);
        handshake();
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_recover_timeout: busy=%b after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic test_threshold_fire();
        exp_t e;
        logic pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        sb.push_back(mk(1'b0, 1));
        sb.push_back(mk(1'b0, 1));
        sb.push_back(mk(1'b0, 2));
        sb.push_back(mk(1'b1, 0));
        for (int i = 0; i < 4; i++) begin
            drive(pat[i], 1'b0);
            e = sb.pop_front();
            checks++;
            if (bus.wake_valid_o !== e.wake || hit !== e.cnt) begin
                failures++;
                $display("FAIL thresh_fire frame %0d: wake=%b hit=%0d, expected wake=%b hit=%0d",
                         i, bus.wake_valid_o, hit, e.wake, e.cnt);
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            checks++;
            if ({bus.wake_valid_o, busy, bus.ready_o, hit} !== {1'b1, 1'b1, 1'b0, TH'(0)}) begin
                failures++;
                $display("FAIL report_hold cycle %0d: wake=%b busy=%b ready=%b hit=%0d, expected 1 1 0 0",
                         i, bus.wake_valid_o, busy, bus.ready_o, hit);
            end
        end
    endtask

    task automatic test_cooldown();
        int n;
        bus.wake_ready_i = 1'b1;
        drive(1'b1, 1'b0);
        bus.wake_ready_i = 1'b0;
        checks++;
        if ({bus.wake_valid_o, busy, bus.ready_o, hit} !== {1'b0, 1'b1, 1'b1, TH'(0)}) begin
            failures++;
            $display("FAIL cooldown_entry: wake=%b busy=%b ready=%b hit=%0d, expected 0 1 1 0",
                     bus.wake_valid_o, busy, bus.ready_o, hit);
        end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0);
            checks++;
            if (hit !== TH'(0)) begin
                failures++;
                $display("FAIL cooldown_hits cycle %0d: hit=%0d, expected 0", i, hit);
            end
            if (busy !== 1'b1) break;
            n++;
        end
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL cooldown_len: busy cycles=%0d, expected 4", n);
        end
    endtask

    task automatic test_window_last();
        exp_t e;
        int   alt_cnt [9] = '{1, 1, 2, 2, 3, 3, 4, 4, 4};
        cfg_write(5, 4);
        for (int i = 1; i <= 4; i++) sb.push_back(mk(1'b0, i));
        sb.push_back(mk(1'b0, 0));
        for (int i = 0; i < 5; i++) begin
            drive(i < 4, i == 4);
            e = sb.pop_front();
            checks++;
            if (bus.wake_valid_o !== e.wake || hit !== e.cnt) begin
                failures++;
                $display("FAIL last_clear frame %0d: wake=%b hit=%0d, expected wake=%b hit=%0d",
                         i, bus.wake_valid_o, hit, e.wake, e.cnt);
            end
        end
        for (int i = 0; i < 9; i++) sb.push_back(mk(1'b0, alt_cnt[i]));
        for (int i = 0; i < 9; i++) begin
            drive((i % 2) == 0, 1'b0);
            e = sb.pop_front();
            checks++;
            if (bus.wake_valid_o !== e.wake || hit !== e.cnt) begin
                failures++;
                $display("FAIL window_slide frame %0d: wake=%b hit=%0d, expected wake=%b hit=%0d",
                         i, bus.wake_valid_o, hit, e.wake, e.cnt);
            end
        end
        drive(1'b0, 1'b1);
    endtask

    task automatic test_edge_configs();
        exp_t e;
        cfg_write(0, 0);
        for (int i = 1; i <= 8; i++) sb.push_back(mk(1'b0, i));
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0);
            e = sb.pop_front();
            checks++;
            if (bus.wake_valid_o !== e.wake || hit !== e.cnt) begin
                failures++;
                $display("FAIL thresh_zero frame %0d: wake=%b hit=%0d, expected wake=%b hit=%0d",
                         i, bus.wake_valid_o, hit, e.wake, e.cnt);
            end
        end
        drive(1'b0, 1'b1);
        cfg_write(2, 0);
        // Second pair: the firing frame also carries last_i.
        for (int k = 0; k < 2; k++) begin
            sb.push_back(mk(1'b0, 1));
            sb.push_back(mk(1'b1, 0));
            for (int i = 0; i < 2; i++) begin
                drive(1'b1, (k == 1) && (i == 1));
                e = sb.pop_front();
                checks++;
                if (bus.wake_valid_o !== e.wake || hit !== e.cnt) begin
                    failures++;
                    $display("FAIL edge_fire pass %0d frame %0d: wake=%b hit=%0d, expected wake=%b hit=%0d",
                             k, i, bus.wake_valid_o, hit, e.wake, e.cnt);
                end
            end
            handshake();
            checks++;
            if ({bus.wake_valid_o, busy, bus.ready_o} !== 3'b001) begin
                failures++;
                $display("FAIL zero_cooldown pass %0d: wake=%b busy=%b ready=%b, expected 0 0 1",
                         k, bus.wake_valid_o, busy, bus.ready_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        cfg_write(1, 0);
        drive(1'b1, 1'b0);
        checks++;
        if (bus.wake_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first: wake=%b, expected 1", bus.wake_valid_o);
        end
        // Frame offered during the handshake cycle must not be taken.
        bus.wake_ready_i = 1'b1;
        drive(1'b1, 1'b0);
        bus.wake_ready_i = 1'b0;
        checks++;
        if ({bus.wake_valid_o, busy, hit} !== {1'b0, 1'b0, TH'(0)}) begin
            failures++;
            $display("FAIL b2b_handshake: wake=%b busy=%b hit=%0d, expected 0 0 0",
                     bus.wake_valid_o, busy, hit);
        end
        drive(1'b1, 1'b0);
        checks++;
        if (bus.wake_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_second: wake=%b, expected 1", bus.wake_valid_o);
        end
        handshake();
    endtask

    task automatic test_enable_cfg();
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0);
            checks++;
            if ({bus.wake_valid_o, bus.ready_o, hit} !== {1'b0, 1'b1, TH'(0)}) begin
                failures++;
                $display("FAIL disabled frame %0d: wake=%b ready=%b hit=%0d, expected 0 1 0",
                         i, bus.wake_valid_o, bus.ready_o, hit);
            end
        end
        enable = 1'b1;
        cfg_write(1, 100);
        drive(1'b1, 1'b0);
        checks++;
        if (bus.wake_valid_o !== 1'b1) begin
            failures++;
            $display("FAIL enable_fire: wake=%b, expected 1", bus.wake_valid_o);
        end
        handshake();
        repeat (10) @(posedge clk);
        #1;
        cfg_write(1, 2);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL shrink_write_edge: busy=%b, expected 1", busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({busy, bus.ready_o} !== 2'b01) begin
            failures++;
            $display("FAIL shrink_exit: busy=%b ready=%b, expected 0 1", busy, bus.ready_o);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        enable           = 1'b1;
        cfg_we           = 1'b0;
        cfg_thresh       = '0;
        cfg_cd           = '0;
        bus.data_i       = '0;
        bus.valid_i      = 1'b0;
        bus.last_i       = 1'b0;
        bus.wake_ready_i = 1'b0;
        test_reset();
        test_threshold_fire();
        test_cooldown();
        test_window_last();
        test_edge_configs();
        test_back_to_back();
        test_enable_cfg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wake_vote_ctrl.md
Name: wake_vote_ctrl

Overview:
- Sequences the wake decision stage.
- Consumes per-frame classifier outputs, keeps a sliding window of wake-class hits and raises one wake event when the hit count reaches a programmable threshold.
- After the event handshake completes, enforces a programmable cooldown.
- Sits between the classifier's streaming output and the downstream wake/sustain logic; applies upstream backpressure only while an event is pending.

Parameters:
- NUM_CLASSES, 3: classifier output width; bit 0 is the wake-word class.
- WINDOW, 8: sliding-window depth in frames, range 1..32.
- CD_BW, 24: cooldown counter / config width.
- DEF_THRESH, 5: reset value of the threshold register.
- DEF_COOLDOWN, 8000000: reset value of the cooldown register, in cycles.
- TH_BW (localparam) = $clog2(WINDOW+1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  arm detection; low = frames drained and ignored
- cfg_we_i  in  1  config write strobe
- cfg_thresh_i  in  TH_BW  threshold value, written on cfg_we_i
- cfg_cooldown_i  in  CD_BW  cooldown length in cycles, written on cfg_we_i
- data_i  in  NUM_CLASSES  classifier frame
- valid_i  in  1  frame valid
- last_i  in  1  final frame of utterance
- ready_o  out  1  frame accept
- wake_valid_o  out  1  wake event pending
- wake_ready_i  in  1  downstream accepts event
- busy_o  out  1  high in REPORT or COOLDOWN
- hit_count_o  out  TH_BW  popcount of the history register

Behaviour:
- One clock domain; all state is updated on posedge clk_i.
- Reset is synchronous and active-high (rst_i). Reset has priority over every other input, including mid-REPORT and mid-COOLDOWN. Reset values:
  - state = ARMED, history = 0, cooldown counter = 0
  - thresh_reg = DEF_THRESH, cd_reg = DEF_COOLDOWN
  - ready_o = 1, wake_valid_o = 0, busy_o = 0, hit_count_o = 0
- Accept rule: a frame is accepted when valid_i & ready_o. ready_o = 1 in ARMED and COOLDOWN, 0 in REPORT.
- Config:
  - cfg_we_i is honoured in any state.
  - Registers update at the next edge; new values apply from the following cycle.
  - thresh_reg = 0 means never fire.
- History: WINDOW-bit shift register. On each accepted ARMED frame with enable_i = 1, shift data_i[0] into bit 0 and discard the oldest bit.
- hit_count_o is combinational popcount(history).
- ARMED:
  - enable_i = 0: accepted frames are dropped; history is cleared each cycle.
  - enable_i = 1, accepted frame: compute cnt_next = popcount(shifted history).
    - If thresh_reg != 0 and cnt_next >= thresh_reg: next state is REPORT and history clears. Latency is exactly 1 cycle: frame accepted at edge N gives wake_valid_o = 1 after edge N.
    - Otherwise, if last_i = 1: history clears (no carry across utterances).
    - Otherwise: history takes the shifted value.
  - Threshold check happens before the last_i clear, so a firing frame with last_i = 1 still fires.
- REPORT:
  - wake_valid_o = 1, ready_o = 0. Stays in REPORT until wake_ready_i = 1; enable_i is ignored here.
  - On handshake: if cd_reg = 0, go to ARMED; otherwise go to COOLDOWN with counter = 0.
  - wake_valid_o drops the cycle after the handshake.
- COOLDOWN:
  - Counter increments every cycle; frames are accepted and dropped; history held at 0.
  - Exit to ARMED when counter >= cd_reg - 1 (live register). A mid-cooldown shrink below the current count therefore exits on the next edge.
  - Total COOLDOWN residency = cd_reg cycles.
- busy_o = (state != ARMED).
- Undefined state encodings recover to ARMED with history = 0.
- Arithmetic: popcount is TH_BW wide. Counter is CD_BW wide and does not wrap, because the exit compare fires first.

Test Plan:
- Reset/defaults: assert rst_i for 2 cycles mid-COOLDOWN -> ready_o = 1, wake_valid_o = 0, busy_o = 0, hit_count_o = 0, thresh = 5.
- Threshold fire: thresh = 3, cooldown = 4; frames with bit0 = 1,0,1,1 -> wake_valid_o = 1 one cycle after 4th accept; ready_o = 0. Hold wake_ready_i = 0 for 5 cycles -> REPORT held.
- Cooldown timing: same setup, wake_ready_i = 1 -> busy_o high for exactly 4 cycles after the handshake. Frames sent during cooldown do not count: hit_count_o stays 0.
- Window slide and last: WINDOW = 8, thresh = 5; 4 hits then frame with last_i = 1 and bit0 = 0 -> no fire, hit_count_o = 0. Next: 9 frames alternating 1,0 -> count never exceeds 4, no event.
- Edge configs: thresh = 0 with 8 hits -> no event. cooldown = 0 -> ARMED the cycle after handshake. Firing frame carrying last_i -> event still raised.
- Enable/config mid-operation: enable_i = 0 with 8 hits -> no event, ready_o = 1. Write cooldown = 2 when counter = 10 of 100 -> ARMED next cycle.
